// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu -- load/store unit between execute and the data bus.
//
// Accepts one load or store at a time, issues a single word-aligned bus
// transaction, aligns and extends load data, and pulses mem_ready for one
// cycle when the access completes (lsu_err qualifies that pulse).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ld_en, st_en             load / store request (held until mem_ready)
//   funct3, addr, st_data    RV32 width code, byte address, store data
//   req_ready                high while idle
//   mem_ready, ld_data       completion pulse and extended load result
//   lsu_err                  misaligned, illegal funct3, bus error or timeout
//   bus_req_valid/ready      request handshake
//   bus_addr, bus_wen        word address, write enable
//   bus_wdata, bus_wmask     lane-shifted write data and byte enables
//   bus_resp_valid, bus_rdata, bus_resp_err   response channel
//
// Optional feature (macro LSU_PERF_EN): adds perf_ld_cnt, perf_st_cnt and
// perf_wait_cnt performance counters.

module ysyx_24080014_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic        st_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        req_ready,
  output logic        mem_ready,
  output logic [31:0] ld_data,
  output logic        lsu_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_wen,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_resp_err
`ifdef LSU_PERF_EN
  ,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t          state;
  logic            is_load;
  logic [2:0]      op_funct3;
  logic [1:0]      op_off;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_inc;

  logic            dec_err;
  logic [3:0]      wmask_dec;
  logic [31:0]     wdata_dec;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     ld_ext;

  assign to_cnt_inc = to_cnt + 1'b1;

  // Decode the incoming request; a load takes priority when both enables are high.
  always_comb begin
    dec_err   = 1'b0;
    wmask_dec = 4'b0000;
    wdata_dec = st_data << {addr[1:0], 3'b000};
    if (ld_en) begin
      case (funct3)
        3'b000, 3'b100: dec_err = 1'b0;
        3'b001, 3'b101: dec_err = addr[0];
        3'b010:         dec_err = (addr[1:0] != 2'b00);
        default:        dec_err = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000: wmask_dec = 4'b0001 << addr[1:0];
        3'b001: begin
          dec_err   = addr[0];
          wmask_dec = 4'b0011 << addr[1:0];
        end
        3'b010: begin
          dec_err   = (addr[1:0] != 2'b00);
          wmask_dec = 4'b1111;
        end
        default: dec_err = 1'b1;
      endcase
    end
  end

  // Pick the addressed byte/half out of the read word and extend it.
  always_comb begin
    case (op_off)
      2'd1:    sel_byte = bus_rdata[15:8];
      2'd2:    sel_byte = bus_rdata[23:16];
      2'd3:    sel_byte = bus_rdata[31:24];
      default: sel_byte = bus_rdata[7:0];
    endcase
    sel_half = op_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_funct3)
      3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
      3'b100:  ld_ext = {24'h0, sel_byte};
      3'b101:  ld_ext = {16'h0, sel_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Control FSM with every output registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      is_load       <= 1'b0;
      op_funct3     <= 3'b000;
      op_off        <= 2'b00;
      to_cnt        <= '0;
      req_ready     <= 1'b1;
      mem_ready     <= 1'b0;
      ld_data       <= 32'h0;
      lsu_err       <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_addr      <= 32'h0;
      bus_wen       <= 1'b0;
      bus_wdata     <= 32'h0;
      bus_wmask     <= 4'b0000;
`ifdef LSU_PERF_EN
      perf_ld_cnt   <= 32'h0;
      perf_st_cnt   <= 32'h0;
      perf_wait_cnt <= 32'h0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_en || st_en) begin
            is_load   <= ld_en;
            op_funct3 <= funct3;
            op_off    <= addr[1:0];
            req_ready <= 1'b0;
            if (dec_err) begin
              // Decode errors complete without touching the bus.
              state     <= S_DONE;
              mem_ready <= 1'b1;
              lsu_err   <= 1'b1;
              ld_data   <= 32'h0;
            end else begin
              state         <= S_REQ;
              bus_req_valid <= 1'b1;
              bus_addr      <= {addr[31:2], 2'b00};
              bus_wen       <= ~ld_en;
              bus_wdata     <= ld_en ? 32'h0 : wdata_dec;
              bus_wmask     <= ld_en ? 4'b0000 : wmask_dec;
            end
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            to_cnt        <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the timeout cycle takes precedence over the timeout.
          if (bus_resp_valid) begin
            state     <= S_DONE;
            mem_ready <= 1'b1;
            lsu_err   <= bus_resp_err;
            ld_data   <= (is_load && !bus_resp_err) ? ld_ext : 32'h0;
          end else if (to_cnt_inc == TO_LIMIT) begin
            to_cnt    <= to_cnt_inc;
            state     <= S_DONE;
            mem_ready <= 1'b1;
            lsu_err   <= 1'b1;
            ld_data   <= 32'h0;
          end else begin
            to_cnt <= to_cnt_inc;
          end
        end
        S_DONE: begin
          // Requests still held high here are not re-accepted until IDLE.
          state     <= S_IDLE;
          mem_ready <= 1'b0;
          lsu_err   <= 1'b0;
          ld_data   <= 32'h0;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
`ifdef LSU_PERF_EN
      if (state == S_REQ || state == S_WAIT) begin
        perf_wait_cnt <= perf_wait_cnt + 32'd1;
      end
      if (state == S_DONE && !lsu_err) begin
        if (is_load) begin
          perf_ld_cnt <= perf_ld_cnt + 32'd1;
        end else begin
          perf_st_cnt <= perf_st_cnt + 32'd1;
        end
      end
`endif
    end
  end

endmodule
